// File: rtl/rfphoenix_wb_tracker_if.sv
// Shared types and the result/writeback bus between the execute/memory paths,
// the writeback tracker and the register scoreboard.
package rfphoenix_wb_pkg;
  localparam int unsigned NREGS = 32;
  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regspec_t;
  typedef logic [NREGS-1:0] regs_bitmap_t;

  // One tracked target: young-window entry or result-1 FIFO slot
  typedef struct packed {
    logic     v;
    regspec_t rt;
  } slot_t;
endpackage

interface rfphoenix_wb_tracker_if;
  import rfphoenix_wb_pkg::*;

  logic         issue_v;
  logic         issue_wr;
  regspec_t     issue_Rt;
  logic         res0_v;
  regspec_t     res0_Rt;
  logic         res1_v;
  regspec_t     res1_Rt;
  logic         res1_rdy;
  logic         flush;
  logic         wb_v;
  regspec_t     wb_Rt;
  logic         rollback;
  regs_bitmap_t rollback_bitmap;

  modport master (
    output issue_v, issue_wr, issue_Rt, res0_v, res0_Rt, res1_v, res1_Rt, flush,
    input  res1_rdy, wb_v, wb_Rt, rollback, rollback_bitmap
  );

  modport slave (
    input  issue_v, issue_wr, issue_Rt, res0_v, res0_Rt, res1_v, res1_Rt, flush,
    output res1_rdy, wb_v, wb_Rt, rollback, rollback_bitmap
  );
endinterface

// File: rtl/rfphoenix_wb_tracker.sv
// Merges ALU and memory results onto one writeback port and tracks young issues
// so that a flush produces a one-cycle rollback bitmap for the scoreboard.
module rfphoenix_wb_tracker
  import rfphoenix_wb_pkg::*;
#(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rfphoenix_wb_tracker_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  slot_t              win_q  [STAGES];
  slot_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               wb_v_q;
  regspec_t           wb_rt_q;
  logic               rollback_q;
  regs_bitmap_t       rollback_bitmap_q;

  logic               issue_rec_c;
  regs_bitmap_t       flush_set_c;
  logic               res1_rdy_c;
  logic               res0_ok_c;
  logic               push_c;
  logic               pop_c;
  slot_t              head_c;
  logic               head_ok_c;
  logic               wb_fire_c;
  regspec_t           wb_rt_c;

  assign issue_rec_c = bus.issue_v & bus.issue_wr & (bus.issue_Rt != '0);

  // Flush set: every valid young target plus a qualifying same-cycle issue
  always_comb begin
    flush_set_c = '0;
    if (bus.flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (win_q[i].v) flush_set_c[win_q[i].rt] = 1'b1;
      end
      if (issue_rec_c) flush_set_c[bus.issue_Rt] = 1'b1;
    end
  end

  // res1_rdy looks at the occupancy only, never at a pop in flight
  assign res1_rdy_c = (count_q < CNT_W'(FIFO_DEPTH));
  assign head_c     = fifo_q[rd_ptr_q];

  // Arbitration: res0 first, else pop the FIFO head (dead heads still pop)
  always_comb begin
    res0_ok_c = bus.res0_v & ~flush_set_c[bus.res0_Rt];
    push_c    = bus.res1_v & res1_rdy_c & ~flush_set_c[bus.res1_Rt];
    pop_c     = ~res0_ok_c & (count_q != '0);
    head_ok_c = pop_c & head_c.v & ~flush_set_c[head_c.rt];
    wb_fire_c = res0_ok_c | head_ok_c;
    wb_rt_c   = res0_ok_c ? bus.res0_Rt : head_c.rt;
  end

  // Young window: shift, drop entries being written back, clear all on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) win_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < STAGES; i++) begin
        win_q[i].v  <= win_q[i-1].v & ~bus.flush &
                       ~(wb_fire_c && (win_q[i-1].rt == wb_rt_c));
        win_q[i].rt <= win_q[i-1].rt;
      end
      win_q[0].v  <= issue_rec_c & ~bus.flush;
      win_q[0].rt <= bus.issue_Rt;
    end
  end

  // Result-1 FIFO; flushed entries are killed in place and freed on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (flush_set_c[fifo_q[i].rt]) fifo_q[i].v <= 1'b0;
      end
      if (push_c) begin
        fifo_q[wr_ptr_q].v  <= 1'b1;
        fifo_q[wr_ptr_q].rt <= bus.res1_Rt;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Registered writeback and rollback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_v_q            <= 1'b0;
      wb_rt_q           <= '0;
      rollback_q        <= 1'b0;
      rollback_bitmap_q <= '0;
    end else begin
      wb_v_q            <= wb_fire_c;
      if (wb_fire_c) wb_rt_q <= wb_rt_c;
      rollback_q        <= bus.flush;
      rollback_bitmap_q <= flush_set_c;
    end
  end

  assign bus.res1_rdy        = res1_rdy_c;
  assign bus.wb_v            = wb_v_q;
  assign bus.wb_Rt           = wb_rt_q;
  assign bus.rollback        = rollback_q;
  assign bus.rollback_bitmap = rollback_bitmap_q;

endmodule

// File: tb/tb_rfphoenix_wb_tracker.sv
// Directed self-checking bench for rfphoenix_wb_tracker.
module tb_rfphoenix_wb_tracker;
  import rfphoenix_wb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   pushed;

  rfphoenix_wb_tracker_if bus ();

  rfphoenix_wb_tracker #(.STAGES(5), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.issue_v  = 1'b0;
    bus.issue_wr = 1'b0;
    bus.issue_Rt = '0;
    bus.res0_v   = 1'b0;
    bus.res0_Rt  = '0;
    bus.res1_v   = 1'b0;
    bus.res1_Rt  = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic issue(input int rt);
    bus.issue_v  = 1'b1;
    bus.issue_wr = 1'b1;
    bus.issue_Rt = regspec_t'(rt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pushed  = 0;
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_wb_v", 32'(bus.wb_v), 0);
    chk("rst_wb_rt", 32'(bus.wb_Rt), 0);
    chk("rst_rollback", 32'(bus.rollback), 0);
    chk("rst_bitmap", bus.rollback_bitmap, 0);
    chk("rst_rdy", 32'(bus.res1_rdy), 1);
    rst_n = 1'b1;
    tick();

    // Issue 5, res0 writes 5 back, later flush sees nothing young
    issue(5);
    tick();
    idle();
    bus.res0_v = 1'b1; bus.res0_Rt = 5'd5;
    tick();
    chk("t1_wb_v", 32'(bus.wb_v), 1);
    chk("t1_wb_rt", 32'(bus.wb_Rt), 5);
    idle();
    tick();
    chk("t1_wb_idle", 32'(bus.wb_v), 0);
    chk("t1_wb_hold", 32'(bus.wb_Rt), 5);
    bus.flush = 1'b1;
    tick();
    chk("t1_rollback", 32'(bus.rollback), 1);
    chk("t1_bitmap", bus.rollback_bitmap, 0);
    idle();
    tick();
    chk("t1_rollback_end", 32'(bus.rollback), 0);

    // res0 and res1 in the same cycle
    bus.res0_v = 1'b1; bus.res0_Rt = 5'd3;
    bus.res1_v = 1'b1; bus.res1_Rt = 5'd9;
    tick();
    chk("t2_wb_rt0", 32'(bus.wb_Rt), 3);
    idle();
    tick();
    chk("t2_wb_v1", 32'(bus.wb_v), 1);
    chk("t2_wb_rt1", 32'(bus.wb_Rt), 9);
    tick();
    chk("t2_wb_idle", 32'(bus.wb_v), 0);

    // res0 held busy for 8 cycles while res1 fills the FIFO
    for (int i = 0; i < 8; i++) begin
      bus.res0_v = 1'b1; bus.res0_Rt = regspec_t'(10 + i);
      bus.res1_v = 1'b1; bus.res1_Rt = regspec_t'(20 + pushed);
      if (bus.res1_rdy) pushed++;
      tick();
      chk("t3_wb_rt", 32'(bus.wb_Rt), 32'(10 + i));
      chk("t3_rdy", 32'(bus.res1_rdy), (i < 3) ? 1 : 0);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_drain_v", 32'(bus.wb_v), 1);
      chk("t3_drain_rt", 32'(bus.wb_Rt), 32'(20 + k));
      if (k == 0) chk("t3_rdy_back", 32'(bus.res1_rdy), 1);
    end
    tick();
    chk("t3_empty", 32'(bus.wb_v), 0);

    // Issue 7, 8, 0 with res1 for 8 stuck behind res0; flush as 12 issues
    issue(7);
    bus.res0_v = 1'b1; bus.res0_Rt = 5'd2;
    bus.res1_v = 1'b1; bus.res1_Rt = 5'd8;
    tick();
    chk("t4_wb_a", 32'(bus.wb_Rt), 2);
    bus.res1_v = 1'b0;
    issue(8);
    tick();
    issue(0);
    tick();
    chk("t4_wb_c", 32'(bus.wb_Rt), 2);
    bus.res0_v = 1'b0;
    issue(12);
    bus.flush = 1'b1;
    tick();
    chk("t4_rollback", 32'(bus.rollback), 1);
    chk("t4_bitmap", bus.rollback_bitmap, 32'h0000_1180);
    chk("t4_no_wb8", 32'(bus.wb_v), 0);
    // Back-to-back flush only carries its own issue
    issue(6);
    bus.flush = 1'b1;
    tick();
    chk("t4b_rollback", 32'(bus.rollback), 1);
    chk("t4b_bitmap", bus.rollback_bitmap, 32'h0000_0040);
    chk("t4b_no_wb", 32'(bus.wb_v), 0);
    idle();
    tick();
    chk("t4_rollback_end", 32'(bus.rollback), 0);
    chk("t4_bitmap_end", bus.rollback_bitmap, 0);
    chk("t4_fifo_empty", 32'(bus.wb_v), 0);

    // Entry ages out of the young window
    issue(4);
    tick();
    idle();
    repeat (6) tick();
    bus.flush = 1'b1;
    tick();
    chk("t5_rollback", 32'(bus.rollback), 1);
    chk("t5_bitmap", bus.rollback_bitmap, 0);
    idle();
    tick();

    // Same-cycle issue and writeback of 11 keeps the new entry
    issue(11);
    tick();
    issue(11);
    bus.res0_v = 1'b1; bus.res0_Rt = 5'd11;
    tick();
    idle();
    bus.flush = 1'b1;
    tick();
    chk("t6_bitmap", bus.rollback_bitmap, 32'h0000_0800);
    idle();
    tick();

    // Asynchronous reset with three FIFO entries pending
    for (int i = 0; i < 3; i++) begin
      bus.res0_v = 1'b1; bus.res0_Rt = 5'd2;
      bus.res1_v = 1'b1; bus.res1_Rt = regspec_t'(13 + i);
      tick();
    end
    idle();
    bus.res0_v = 1'b1; bus.res0_Rt = 5'd2;
    bus.flush  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_wb_v", 32'(bus.wb_v), 0);
    chk("t7_wb_rt", 32'(bus.wb_Rt), 0);
    chk("t7_rollback", 32'(bus.rollback), 0);
    chk("t7_rdy", 32'(bus.res1_rdy), 1);
    idle();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t7_no_wb", 32'(bus.wb_v), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
